pixel_stream_fifo: RTL and testbench
====================================

PIXEL_STREAM_FIFO -- requirements
Module: pixel_stream_fifo

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 24, giving the bits per pixel.
REQ-002 SHALL have parameter PIXELS_PER_BEAT, default 4, giving the pixels per stream beat; DATA_WIDTH = PIXEL_WIDTH*PIXELS_PER_BEAT.
REQ-003 SHALL have parameter DEPTH, default 8, giving the FIFO entries; it is a power of two and at least 2.
REQ-004 SHALL have parameter LEN_WIDTH, default 16, giving the width of the beat counters.
REQ-005 clk_i  in  1  the single clock; all state SHALL update on its rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous and active-low.
REQ-007 clear_i  in  1  synchronous soft clear, active-high.
REQ-008 start_i  in  1  one-cycle start pulse.
REQ-009 len_i  in  LEN_WIDTH  transfer length in beats, sampled on start.
REQ-010 in_data_i  in  DATA_WIDTH  input beat.
REQ-011 in_valid_i  in  1  input valid.
REQ-012 in_ready_o  out  1  input ready.
REQ-013 out_data_o  out  DATA_WIDTH  output beat.
REQ-014 out_valid_o  out  1  output valid.
REQ-015 out_ready_i  in  1  output ready.
REQ-016 busy_o  out  1  transfer in progress.
REQ-017 done_o  out  1  one-cycle end-of-transfer pulse.
REQ-018 in_cnt_o / out_cnt_o  out  LEN_WIDTH each  beats accepted / beats delivered in the current transfer.
REQ-019 full_o / empty_o  out  1 each  FIFO status.

Function
REQ-020 A beat SHALL transfer on a port only in a cycle where valid and ready are both 1.
REQ-021 While out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o SHALL hold stable.
REQ-022 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-023 IDLE->RUN on start_i with len_i!=0; this latches len_i and zeroes both counters.
REQ-024 start_i with len_i==0 in IDLE SHALL pulse done_o in the next cycle and stay in IDLE.
REQ-025 start_i outside IDLE SHALL be ignored.
REQ-026 in_ready_o SHALL be 1 only when state==RUN, the FIFO is not full and in_cnt<len.
REQ-027 RUN->DRAIN in the cycle after in_cnt reaches len.
REQ-028 DRAIN->DONE once out_cnt==len and the FIFO is empty.
REQ-029 DONE SHALL assert done_o for exactly 1 cycle and then go to IDLE.
REQ-030 busy_o SHALL equal (state==RUN or state==DRAIN).
REQ-031 The FIFO SHALL have registered output: a beat written into an empty FIFO at edge N is visible on out_data_o with out_valid_o=1 after edge N+1; there is no combinational in-to-out path.
REQ-032 out_valid_o SHALL equal !empty.
REQ-033 A simultaneous push and pop SHALL leave the occupancy unchanged and preserve order.
REQ-034 When full, in_ready_o=0 even if a pop occurs in the same cycle.
REQ-035 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished using an extra pointer bit.
REQ-036 Counters SHALL increment by 1 per accepted or delivered beat and never exceed len.
REQ-037 Data SHALL pass bit-exact; pixel p occupies bits [p*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-038 clear_i SHALL have priority over all other inputs: it flushes the FIFO, zeroes the counters and pointers, sets the state to IDLE and suppresses done_o, all in one cycle.

Reset
REQ-039 On rst_ni=0 the block SHALL immediately enter state IDLE with pointers=0 and counters=0.
REQ-040 During reset: in_ready_o=0, out_valid_o=0, busy_o=0, done_o=0, full_o=0, empty_o=1.
REQ-041 During reset out_data_o SHALL be 0.
REQ-042 Reset asserted mid-transfer SHALL discard all buffered beats, and no done_o SHALL follow.

Verification
REQ-043 Basic: len=5, out_ready_i=1, input valid every cycle -> 5 beats out in order; done_o pulses once; in_cnt_o=out_cnt_o=5 at done.
REQ-044 Backpressure: DEPTH=8, len=20, out_ready_i=0 -> exactly 8 beats accepted, full_o=1, in_ready_o=0; releasing out_ready_i -> all 20 beats arrive in order.
REQ-045 Wrap and concurrency: len=100, random valid/ready at 50% -> output sequence equals input sequence; data stable under stall; pointers wrap at least 12 times.
REQ-046 Zero length: start with len=0 -> done_o pulses one cycle later; busy_o stays 0.
REQ-047 Clear mid-transfer: len=10, clear_i asserted after 4 beats -> empty_o=1, state IDLE, no done_o; a new start with len=3 then completes normally.
REQ-048 Async reset: rst_ni driven low between clock edges in DRAIN -> outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/pixel_stream_fifo_if.sv
// Pixel stream handshake bundle: one input beat channel and one output beat
// channel, each with valid/ready.
//   slave  : the FIFO side (accepts in_*, produces out_*)
//   master : the producer/consumer side driving in_* and out_ready_i
interface pixel_stream_fifo_if #(
    parameter int unsigned DATA_WIDTH = 96
) ();
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_valid_o;
    logic                  out_ready_i;

    modport slave (
        input  in_data_i,
        input  in_valid_i,
        output in_ready_o,
        output out_data_o,
        output out_valid_o,
        input  out_ready_i
    );

    modport master (
        output in_data_i,
        output in_valid_i,
        input  in_ready_o,
        input  out_data_o,
        input  out_valid_o,
        output out_ready_i
    );
endinterface

// File: rtl/pixel_stream_fifo.sv
// Length-controlled pixel stream FIFO. A start pulse with a non-zero length
// opens a transfer of len beats; beats are buffered in a DEPTH-entry FIFO whose
// head sits in an output register, and done_o pulses once every beat has been
// delivered.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   clear_i               synchronous flush back to IDLE
//   start_i, len_i        transfer start pulse and length in beats
//   stream (slave)        in_data/in_valid/in_ready, out_data/out_valid/out_ready
//   busy_o, done_o        transfer in progress / end-of-transfer pulse
//   in_cnt_o, out_cnt_o   beats accepted / delivered in the current transfer
//   full_o, empty_o       FIFO status (empty_o == !out_valid)
module pixel_stream_fifo #(
    parameter int unsigned PIXEL_WIDTH     = 24,
    parameter int unsigned PIXELS_PER_BEAT = 4,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned LEN_WIDTH       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    pixel_stream_fifo_if.slave    stream,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LEN_WIDTH-1:0]  in_cnt_o,
    output logic [LEN_WIDTH-1:0]  out_cnt_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned DATA_WIDTH = PIXEL_WIDTH * PIXELS_PER_BEAT;
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam int unsigned PW         = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;

    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_in_cnt;
    logic [LEN_WIDTH-1:0]  r_out_cnt;
    logic                  r_zero_done;

    logic [PW-1:0]         w_mem_cnt;
    logic [PW-1:0]         w_occ;
    logic                  w_mem_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_in_ready;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_start_run;
    logic                  w_start_zero;

    // Occupancy counts the output register as one entry so total capacity is DEPTH.
    assign w_mem_cnt    = r_wptr - r_rptr;
    assign w_occ        = w_mem_cnt + PW'(r_out_valid);
    assign w_mem_empty  = (r_wptr == r_rptr);
    assign w_full       = (w_occ == PW'(DEPTH));

    assign w_push       = stream.in_valid_i & w_in_ready;
    assign w_pop        = r_out_valid & stream.out_ready_i;
    // Refill the output register whenever it is empty or being drained.
    assign w_load       = ~w_mem_empty & (~r_out_valid | w_pop);

    assign w_start_run  = (r_state == S_IDLE) & start_i & (len_i != '0);
    assign w_start_zero = (r_state == S_IDLE) & start_i & (len_i == '0);

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; clear overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_run) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_in_cnt == r_len) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((r_out_cnt == r_len) && w_mem_empty && !r_out_valid) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // FSM outputs, decoded from registered state only
    always_comb begin
        w_busy     = 1'b0;
        w_done     = r_zero_done;
        w_in_ready = 1'b0;
        case (r_state)
            S_RUN: begin
                w_busy     = 1'b1;
                w_in_ready = ~w_full & (r_in_cnt < r_len);
            end
            S_DRAIN: begin
                w_busy = 1'b1;
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Transfer length and beat counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len       <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_zero_done <= 1'b0;
        end else if (clear_i) begin
            r_len       <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_start_zero;
            if (w_start_run) begin
                r_len     <= len_i;
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_push && (r_in_cnt < r_len)) begin
                    r_in_cnt <= r_in_cnt + LEN_WIDTH'(1);
                end
                if (w_pop && (r_out_cnt < r_len)) begin
                    r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
                end
            end
        end
    end

    // Pointers and registered FIFO head
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (clear_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_load) begin
                r_out_data  <= r_mem[r_rptr[AW-1:0]];
                r_out_valid <= 1'b1;
                r_rptr      <= r_rptr + PW'(1);
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Storage array; contents are qualified by the pointers, so no reset
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= stream.in_data_i;
        end
    end

    assign stream.in_ready_o  = w_in_ready;
    assign stream.out_data_o  = r_out_data;
    assign stream.out_valid_o = r_out_valid;
    assign busy_o             = w_busy;
    assign done_o             = w_done;
    assign in_cnt_o           = r_in_cnt;
    assign out_cnt_o          = r_out_cnt;
    assign full_o             = w_full;
    assign empty_o            = ~r_out_valid;

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Self-checking bench for pixel_stream_fifo: table of transfer scenarios plus
// hand-written corner sequences, with a queue scoreboard on the data path.
module tb_pixel_stream_fifo;

    localparam int unsigned PXW   = 24;
    localparam int unsigned PPB   = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = 16;
    localparam int unsigned DW    = PXW * PPB;

    typedef struct {
        logic [LW-1:0] len;
        int unsigned   vpct;
        int unsigned   rpct;
        logic [LW-1:0] exp_cnt;
        int            exp_dones;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          start_i;
    logic [LW-1:0] len_i;
    logic          busy_o;
    logic          done_o;
    logic [LW-1:0] in_cnt_o;
    logic [LW-1:0] out_cnt_o;
    logic          full_o;
    logic          empty_o;

    pixel_stream_fifo_if #(.DATA_WIDTH(DW)) s_if ();

    pixel_stream_fifo #(
        .PIXEL_WIDTH     (PXW),
        .PIXELS_PER_BEAT (PPB),
        .DEPTH           (DEPTH),
        .LEN_WIDTH       (LW)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .start_i   (start_i),
        .len_i     (len_i),
        .stream    (s_if),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .in_cnt_o  (in_cnt_o),
        .out_cnt_o (out_cnt_o),
        .full_o    (full_o),
        .empty_o   (empty_o)
    );

    always #5 clk_i = ~clk_i;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            n_done   = 0;
    int            n_push   = 0;
    logic [LW-1:0] done_in;
    logic [LW-1:0] done_out;
    bit            hold_pend = 1'b0;
    logic [DW-1:0] hold_data;
    logic [DW-1:0] sb [$];
    vec_t          vecs [5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle, entered and left at a falling edge; handshakes are judged on
    // the registered outputs seen at entry, which cannot change before the
    // rising edge that completes them.
    task automatic drive_cycle(input bit v, input bit r);
        logic [DW-1:0] d;
        if (hold_pend) begin
            chk("stall_valid", 128'(s_if.out_valid_o), 128'(1));
            chk("stall_data", 128'(s_if.out_data_o), 128'(hold_data));
        end
        if (done_o) begin
            n_done++;
            done_in  = in_cnt_o;
            done_out = out_cnt_o;
        end
        d = {$urandom(), $urandom(), $urandom()};
        s_if.in_data_i   = d;
        s_if.in_valid_i  = v;
        s_if.out_ready_i = r;
        if (v && s_if.in_ready_o && !clear_i) begin
            sb.push_back(d);
            n_push++;
        end
        if (r && s_if.out_valid_o && !clear_i) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h expected no beat", s_if.out_data_o);
            end else begin
                chk("beat_data", 128'(s_if.out_data_o), 128'(sb.pop_front()));
            end
        end
        hold_pend = s_if.out_valid_o && !r && !clear_i;
        hold_data = s_if.out_data_o;
        @(negedge clk_i);
    endtask

    task automatic do_start(input logic [LW-1:0] len, input bit r);
        start_i = 1'b1;
        len_i   = len;
        drive_cycle(1'b0, r);
        start_i = 1'b0;
    endtask

    task automatic run_transfer(input vec_t v);
        int budget;
        int cyc;
        budget = int'(v.len) * 20 + 100;
        cyc    = 0;
        n_done = 0;
        do_start(v.len, 1'b0);
        chk("busy_after_start", 128'(busy_o), 128'(1));
        while (n_done == 0 && cyc < budget) begin
            drive_cycle($urandom_range(99) < v.vpct, $urandom_range(99) < v.rpct);
            cyc++;
        end
        if (n_done == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL transfer_timeout: got no done after %0d cycles, required done (len=%0d)", cyc, v.len);
        end
        chk("done_in_cnt", 128'(done_in), 128'(v.exp_cnt));
        chk("done_out_cnt", 128'(done_out), 128'(v.exp_cnt));
        chk("sb_drained", 128'(sb.size()), 128'(0));
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1);
        chk("done_once", 128'(n_done), 128'(v.exp_dones));
        chk("busy_after_done", 128'(busy_o), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        vecs[0] = '{16'd5,   100, 100, 16'd5,   1};
        vecs[1] = '{16'd20,  100, 30,  16'd20,  1};
        vecs[2] = '{16'd100, 50,  50,  16'd100, 1};
        vecs[3] = '{16'd1,   100, 100, 16'd1,   1};
        vecs[4] = '{16'd17,  30,  90,  16'd17,  1};

        rst_ni           = 1'b0;
        clear_i          = 1'b0;
        start_i          = 1'b0;
        len_i            = '0;
        s_if.in_data_i   = '0;
        s_if.in_valid_i  = 1'b0;
        s_if.out_ready_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);

        // reset values
        chk("rst_in_ready", 128'(s_if.in_ready_o), 128'(0));
        chk("rst_out_valid", 128'(s_if.out_valid_o), 128'(0));
        chk("rst_out_data", 128'(s_if.out_data_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_full", 128'(full_o), 128'(0));
        chk("rst_empty", 128'(empty_o), 128'(1));
        chk("rst_in_cnt", 128'(in_cnt_o), 128'(0));
        chk("rst_out_cnt", 128'(out_cnt_o), 128'(0));
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 5; i++) run_transfer(vecs[i]);

        // zero length: done next cycle, never busy
        do_start(16'd0, 1'b1);
        chk("zero_done", 128'(done_o), 128'(1));
        chk("zero_busy", 128'(busy_o), 128'(0));
        drive_cycle(1'b0, 1'b1);
        chk("zero_done_end", 128'(done_o), 128'(0));
        chk("zero_busy_end", 128'(busy_o), 128'(0));

        // registered-output latency then backpressure to full
        n_push = 0;
        n_done = 0;
        do_start(16'd20, 1'b0);
        drive_cycle(1'b1, 1'b0);
        chk("lat_valid_edge_n", 128'(s_if.out_valid_o), 128'(0));
        chk("lat_empty_edge_n", 128'(empty_o), 128'(1));
        drive_cycle(1'b1, 1'b0);
        chk("lat_valid_edge_n1", 128'(s_if.out_valid_o), 128'(1));
        for (int i = 0; i < 18; i++) drive_cycle(1'b1, 1'b0);
        chk("bp_accepted", 128'(n_push), 128'(8));
        chk("bp_in_cnt", 128'(in_cnt_o), 128'(8));
        chk("bp_full", 128'(full_o), 128'(1));
        chk("bp_in_ready", 128'(s_if.in_ready_o), 128'(0));
        cyc = 0;
        while (n_done == 0 && cyc < 400) begin
            drive_cycle(1'b1, 1'b1);
            cyc++;
        end
        chk("bp_done_seen", 128'(n_done), 128'(1));
        chk("bp_out_cnt", 128'(done_out), 128'(20));
        chk("bp_sb_drained", 128'(sb.size()), 128'(0));
        drive_cycle(1'b0, 1'b1);

        // clear after four buffered beats
        n_push = 0;
        do_start(16'd10, 1'b0);
        cyc = 0;
        while (n_push < 4 && cyc < 50) begin
            drive_cycle(1'b1, 1'b0);
            cyc++;
        end
        clear_i = 1'b1;
        drive_cycle(1'b0, 1'b0);
        clear_i = 1'b0;
        sb.delete();
        chk("clr_empty", 128'(empty_o), 128'(1));
        chk("clr_out_valid", 128'(s_if.out_valid_o), 128'(0));
        chk("clr_busy", 128'(busy_o), 128'(0));
        chk("clr_in_cnt", 128'(in_cnt_o), 128'(0));
        chk("clr_out_cnt", 128'(out_cnt_o), 128'(0));
        n_done = 0;
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1);
        chk("clr_no_done", 128'(n_done), 128'(0));
        run_transfer('{16'd3, 100, 100, 16'd3, 1});

        // asynchronous reset while draining
        do_start(16'd6, 1'b0);
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0);
        chk("drain_busy", 128'(busy_o), 128'(1));
        chk("drain_valid", 128'(s_if.out_valid_o), 128'(1));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_out_valid", 128'(s_if.out_valid_o), 128'(0));
        chk("arst_out_data", 128'(s_if.out_data_o), 128'(0));
        chk("arst_empty", 128'(empty_o), 128'(1));
        chk("arst_busy", 128'(busy_o), 128'(0));
        chk("arst_in_cnt", 128'(in_cnt_o), 128'(0));
        chk("arst_done", 128'(done_o), 128'(0));
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni    = 1'b1;
        hold_pend = 1'b0;
        sb.delete();
        n_done = 0;
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1);
        chk("arst_no_done", 128'(n_done), 128'(0));
        run_transfer('{16'd4, 100, 100, 16'd4, 1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
